scr1_tcm_mp: RTL and testbench

SCR1_TCM_MP -- requirements
Module: scr1_tcm_mp

---
 rtl/scr1_tcm_mp.sv | 184 ++++++++++++++++++
 tb/tb_scr1_tcm_mp.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_mp.sv
// Tightly-coupled memory: read-only fetch port A, plus a read/write port B that
// the core and NACC accelerator channels share through an arbiter.
module scr1_tcm_mp #(
    parameter logic [31:0] TCM_SIZE = 32'h0001_0000,
    parameter int          NACC     = 2,
    parameter int          ARB_MODE = 0,
    localparam int         AW       = $clog2(TCM_SIZE),
    localparam int         WW       = AW - 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_req,
    output logic                 imem_req_ack,
    input  logic [31:0]          imem_addr,
    output logic [31:0]          imem_rdata,
    output logic [1:0]           imem_resp,
    input  logic                 dmem_req,
    output logic                 dmem_req_ack,
    input  logic                 dmem_cmd,
    input  logic [1:0]           dmem_width,
    input  logic [31:0]          dmem_addr,
    input  logic [31:0]          dmem_wdata,
    output logic [31:0]          dmem_rdata,
    output logic [1:0]           dmem_resp,
    input  logic [NACC-1:0]      acc_req,
    output logic [NACC-1:0]      acc_ack,
    input  logic [NACC-1:0]      acc_we,
    input  logic [NACC*WW-1:0]   acc_addr,
    input  logic [NACC*32-1:0]   acc_wdata,
    input  logic [NACC*4-1:0]    acc_be,
    output logic [31:0]          acc_rdata,
    output logic [NACC-1:0]      acc_rvalid
);

    localparam int          DEPTH       = int'(TCM_SIZE >> 2);
    localparam int          NREQ        = NACC + 1;
    localparam int          PW          = $clog2(NREQ);
    localparam logic [1:0]  RESP_NOTRDY = 2'b00;
    localparam logic [1:0]  RESP_OK     = 2'b01;
    localparam logic [1:0]  RESP_ER     = 2'b10;

    logic [31:0]     mem [DEPTH];
    logic [31:0]     imem_rdata_q;
    logic [31:0]     b_rdata_q;

    logic [NREQ-1:0] req_vec;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic            imem_err, imem_rd;
    logic            core_err;
    logic [3:0]      core_be;
    logic [31:0]     core_wdata;

    logic            b_we, b_rd;
    logic [WW-1:0]   b_idx;
    logic [31:0]     b_wdata;
    logic [3:0]      b_be;

    logic [1:0]      imem_resp_q, imem_resp_d;
    logic [1:0]      dmem_resp_q, dmem_resp_d;
    logic            core_rd_q, core_rd_d;
    logic [1:0]      off_q, off_d;
    logic [NACC-1:0] acc_rv_q, acc_rv_d;
    logic [31:0]     dmem_hold_q, dmem_hold_d;
    logic [31:0]     acc_hold_q, acc_hold_d;

    // Requester 0 is the core; requester i+1 is accelerator channel i.
    always_comb begin
        int            idx;
        logic [PW-1:0] sel;
        req_vec = {acc_req, dmem_req};
        gnt     = '0;
        ptr_d   = ptr_q;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ARB_MODE == 1) ? (int'(ptr_q) + k) % NREQ : k;
            sel = PW'(idx);
            if (gnt == '0 && req_vec[sel]) begin
                gnt[sel] = 1'b1;
                ptr_d    = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    assign dmem_req_ack = gnt[0];
    assign acc_ack      = gnt[NREQ-1:1];
    assign imem_req_ack = 1'b1;

    always_comb begin
        core_err   = (dmem_addr >= TCM_SIZE);
        core_be    = 4'b1111;
        core_wdata = dmem_wdata;
        case (dmem_width)
            2'd0: begin
                core_be    = 4'b0001 << dmem_addr[1:0];
                core_wdata = {4{dmem_wdata[7:0]}};
            end
            2'd1: begin
                core_err   = core_err | dmem_addr[0];
                core_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                core_wdata = {2{dmem_wdata[15:0]}};
            end
            2'd2:    core_err = core_err | (dmem_addr[1:0] != 2'b00);
            default: core_err = 1'b1;
        endcase
    end

    // Port B operand mux; an erroring core access is acked but never reaches the array.
    always_comb begin
        b_we    = 1'b0;
        b_rd    = 1'b0;
        b_idx   = dmem_addr[AW-1:2];
        b_wdata = core_wdata;
        b_be    = core_be;
        if (gnt[0] && !core_err) begin
            b_we = dmem_cmd;
            b_rd = !dmem_cmd;
        end
        for (int i = 0; i < NACC; i++) begin
            if (gnt[i+1]) begin
                b_idx   = acc_addr[i*WW +: WW];
                b_wdata = acc_wdata[i*32 +: 32];
                b_be    = acc_be[i*4 +: 4];
                b_we    = acc_we[i];
                b_rd    = !acc_we[i];
            end
        end
    end

    always_comb begin
        imem_err    = (imem_addr[1:0] != 2'b00) || (imem_addr >= TCM_SIZE);
        imem_rd     = imem_req && !imem_err;
        imem_resp_d = !imem_req ? RESP_NOTRDY : (imem_err ? RESP_ER : RESP_OK);
        dmem_resp_d = !gnt[0] ? RESP_NOTRDY : (core_err ? RESP_ER : RESP_OK);
        core_rd_d   = gnt[0] && !core_err && !dmem_cmd;
        off_d       = core_rd_d ? dmem_addr[1:0] : off_q;
        acc_rv_d    = gnt[NREQ-1:1] & ~acc_we;
        dmem_rdata  = core_rd_q ? (b_rdata_q >> {off_q, 3'b000}) : dmem_hold_q;
        acc_rdata   = (|acc_rv_q) ? b_rdata_q : acc_hold_q;
        dmem_hold_d = dmem_rdata;
        acc_hold_d  = acc_rdata;
    end

    // Array has no reset; nonblocking read-before-write gives port A the old word.
    always_ff @(posedge clk) begin
        if (imem_rd) imem_rdata_q <= mem[imem_addr[AW-1:2]];
        if (b_rd)    b_rdata_q    <= mem[b_idx];
        if (b_we) begin
            for (int j = 0; j < 4; j++) begin
                if (b_be[j]) mem[b_idx][j*8 +: 8] <= b_wdata[j*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            imem_resp_q <= RESP_NOTRDY;
            dmem_resp_q <= RESP_NOTRDY;
            core_rd_q   <= 1'b0;
            off_q       <= 2'b00;
            acc_rv_q    <= '0;
            dmem_hold_q <= '0;
            acc_hold_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            imem_resp_q <= imem_resp_d;
            dmem_resp_q <= dmem_resp_d;
            core_rd_q   <= core_rd_d;
            off_q       <= off_d;
            acc_rv_q    <= acc_rv_d;
            dmem_hold_q <= dmem_hold_d;
            acc_hold_q  <= acc_hold_d;
        end
    end

    assign imem_rdata = imem_rdata_q;
    assign imem_resp  = imem_resp_q;
    assign dmem_resp  = dmem_resp_q;
    assign acc_rvalid = acc_rv_q;

endmodule

// File: tb/tb_scr1_tcm_mp.sv
// Bench for scr1_tcm_mp: a fixed-priority and a round-robin instance share one
// stimulus stream; each is checked against its own byte-level memory model.
module tb_scr1_tcm_mp;

    localparam int SZ   = 1024;
    localparam int NACC = 2;
    localparam int WW   = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              dmem_req;
    logic              dmem_cmd;
    logic [1:0]        dmem_width;
    logic [31:0]       dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [NACC-1:0]   acc_req;
    logic [NACC-1:0]   acc_we;
    logic [NACC*WW-1:0] acc_addr;
    logic [NACC*32-1:0] acc_wdata;
    logic [NACC*4-1:0]  acc_be;

    logic [1:0]        imem_req_ack_o;
    logic [1:0][31:0]  imem_rdata_o;
    logic [1:0][1:0]   imem_resp_o;
    logic [1:0]        dmem_req_ack_o;
    logic [1:0][31:0]  dmem_rdata_o;
    logic [1:0][1:0]   dmem_resp_o;
    logic [1:0][1:0]   acc_ack_o;
    logic [1:0][31:0]  acc_rdata_o;
    logic [1:0][1:0]   acc_rvalid_o;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        scr1_tcm_mp #(
            .TCM_SIZE (32'(SZ)),
            .NACC     (NACC),
            .ARB_MODE (m)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .imem_req     (imem_req),
            .imem_req_ack (imem_req_ack_o[m]),
            .imem_addr    (imem_addr),
            .imem_rdata   (imem_rdata_o[m]),
            .imem_resp    (imem_resp_o[m]),
            .dmem_req     (dmem_req),
            .dmem_req_ack (dmem_req_ack_o[m]),
            .dmem_cmd     (dmem_cmd),
            .dmem_width   (dmem_width),
            .dmem_addr    (dmem_addr),
            .dmem_wdata   (dmem_wdata),
            .dmem_rdata   (dmem_rdata_o[m]),
            .dmem_resp    (dmem_resp_o[m]),
            .acc_req      (acc_req),
            .acc_ack      (acc_ack_o[m]),
            .acc_we       (acc_we),
            .acc_addr     (acc_addr),
            .acc_wdata    (acc_wdata),
            .acc_be       (acc_be),
            .acc_rdata    (acc_rdata_o[m]),
            .acc_rvalid   (acc_rvalid_o[m])
        );
    end

    // Reference model state, one copy per instance.
    logic [7:0]  mb [2][SZ];
    int          ptr_m [2];
    logic [2:0]  obs_ack [2];
    logic [1:0]  exp_iresp;
    logic [31:0] exp_irdata [2];
    logic [1:0]  exp_dresp [2];
    logic [31:0] exp_drdata [2];
    logic [1:0]  exp_arv [2];
    logic [31:0] exp_ardata [2];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int m, input int w);
        return {mb[m][4*w+3], mb[m][4*w+2], mb[m][4*w+1], mb[m][4*w]};
    endfunction

    function automatic bit core_err_f(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00) || (a >= SZ);
    endfunction

    function automatic int arb(input int mode, input logic [2:0] req, input int ptr);
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = (mode == 1) ? (ptr + k) % 3 : k;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_iresp = 2'b00;
        for (int m = 0; m < 2; m++) begin
            ptr_m[m]      = 0;
            exp_dresp[m]  = 2'b00;
            exp_drdata[m] = '0;
            exp_arv[m]    = 2'b00;
            exp_ardata[m] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("d%0d_imem_resp", m), 32'(imem_resp_o[m]), 32'(exp_iresp));
            if (exp_iresp == 2'b01)
                chk($sformatf("d%0d_imem_rdata", m), imem_rdata_o[m], exp_irdata[m]);
            chk($sformatf("d%0d_dmem_resp", m), 32'(dmem_resp_o[m]), 32'(exp_dresp[m]));
            chk($sformatf("d%0d_dmem_rdata", m), dmem_rdata_o[m], exp_drdata[m]);
            chk($sformatf("d%0d_acc_rvalid", m), 32'(acc_rvalid_o[m]), 32'(exp_arv[m]));
            chk($sformatf("d%0d_acc_rdata", m), acc_rdata_o[m], exp_ardata[m]);
        end
    endtask

    // Inputs are already driven; checks grants, advances the model, then checks responses.
    task automatic cycle();
        int         g;
        int         a;
        int         w;
        logic [31:0] rd;
        logic [2:0] reqv;
        bit         cerr;
        logic [1:0] n_iresp;
        #1;
        reqv    = {acc_req, dmem_req};
        cerr    = core_err_f(dmem_width, dmem_addr);
        n_iresp = !imem_req ? 2'b00 :
                  ((imem_addr[1:0] != 2'b00 || imem_addr >= SZ) ? 2'b10 : 2'b01);
        for (int m = 0; m < 2; m++) begin
            g = arb(m, reqv, ptr_m[m]);
            obs_ack[m] = {acc_ack_o[m], dmem_req_ack_o[m]};
            chk($sformatf("d%0d_imem_ack", m), 32'(imem_req_ack_o[m]), 32'd1);
            chk($sformatf("d%0d_port_b_ack", m), 32'(obs_ack[m]), (g >= 0) ? (32'd1 << g) : 32'd0);
            if (n_iresp == 2'b01) exp_irdata[m] = mword(m, int'(imem_addr) / 4);
            exp_dresp[m] = (g == 0) ? (cerr ? 2'b10 : 2'b01) : 2'b00;
            if (g == 0 && !cerr && !dmem_cmd) begin
                a  = int'(dmem_addr);
                rd = '0;
                for (int i = 0; i < 4 - (a % 4); i++) rd[8*i +: 8] = mb[m][a+i];
                exp_drdata[m] = rd;
            end
            exp_arv[m] = 2'b00;
            if (g >= 1 && !acc_we[g-1]) begin
                exp_arv[m]    = 2'(1 << (g - 1));
                exp_ardata[m] = mword(m, int'(acc_addr[(g-1)*WW +: WW]));
            end
            if (g == 0 && !cerr && dmem_cmd) begin
                a = int'(dmem_addr);
                for (int i = 0; i < (1 << dmem_width); i++) mb[m][a+i] = dmem_wdata[8*i +: 8];
            end
            if (g >= 1 && acc_we[g-1]) begin
                w = int'(acc_addr[(g-1)*WW +: WW]);
                for (int j = 0; j < 4; j++)
                    if (acc_be[(g-1)*4 + j]) mb[m][4*w + j] = acc_wdata[(g-1)*32 + 8*j +: 8];
            end
            if (g >= 0) ptr_m[m] = (g + 1) % 3;
        end
        exp_iresp = n_iresp;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_idle();
        imem_req   = 1'b0;
        imem_addr  = '0;
        dmem_req   = 1'b0;
        dmem_cmd   = 1'b0;
        dmem_width = 2'd2;
        dmem_addr  = '0;
        dmem_wdata = '0;
        acc_req    = '0;
        acc_we     = '0;
        acc_addr   = '0;
        acc_wdata  = '0;
        acc_be     = '0;
    endtask

    task automatic rand_inputs();
        int r;
        int base;
        imem_req = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r < 7)       imem_addr = 32'($urandom_range(0, SZ/4 - 1)) * 4;
        else if (r == 7) imem_addr = 32'($urandom_range(0, SZ - 1));
        else             imem_addr = 32'(SZ + $urandom_range(0, 4095)) & ~32'd3;
        dmem_req   = 1'($urandom_range(0, 1));
        dmem_cmd   = 1'($urandom_range(0, 1));
        dmem_width = 2'($urandom_range(0, 3));
        dmem_wdata = $urandom;
        base = $urandom_range(0, SZ - 1);
        if ($urandom_range(0, 3) != 0 && dmem_width != 2'd3) base = base & ~((1 << dmem_width) - 1);
        if ($urandom_range(0, 15) == 0) base = base + SZ;
        dmem_addr = 32'(base);
        acc_req   = 2'($urandom);
        acc_we    = 2'($urandom);
        acc_addr  = 16'($urandom);
        acc_wdata = {$urandom, $urandom};
        acc_be    = 8'($urandom);
    endtask

    initial begin
        set_idle();
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // All three requesters writing from reset: fixed priority keeps the core,
        // round-robin rotates 0,1,2,...
        dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd2; dmem_addr = 32'h20;
        acc_req = 2'b11; acc_we = 2'b11; acc_be = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            dmem_wdata = $urandom;
            acc_addr   = 16'($urandom);
            acc_wdata  = {$urandom, $urandom};
            cycle();
            chk("fixed_core_only", 32'(obs_ack[0]), 32'd1);
            chk($sformatf("rr_grant_%0d", k), 32'(obs_ack[1]), 32'd1 << (k % 3));
        end

        // Fill every word through accelerator 0 so later reads are defined.
        set_idle();
        acc_req = 2'b01; acc_we = 2'b01; acc_be = 8'h0F;
        for (int w = 0; w < SZ/4; w++) begin
            acc_addr  = 16'(w);
            acc_wdata = {32'h0, $urandom};
            cycle();
        end

        set_idle();
        dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd2; dmem_addr = 32'h10; dmem_wdata = 32'hA5A5_1234;
        cycle();
        dmem_cmd = 1'b0; dmem_width = 2'd0; dmem_addr = 32'h13;
        cycle();
        chk("byte_rd_resp", 32'(dmem_resp_o[0]), 32'd1);
        chk("byte_rd_data", 32'(dmem_rdata_o[0][7:0]), 32'hA5);

        dmem_width = 2'd1; dmem_addr = 32'h11;
        cycle();
        chk("misalign_ack", 32'(obs_ack[0]), 32'd1);
        chk("misalign_resp", 32'(dmem_resp_o[0]), 32'd2);
        dmem_cmd = 1'b1; dmem_wdata = 32'h0000_FFFF;
        cycle();
        dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'h10;
        cycle();
        chk("misalign_no_write", dmem_rdata_o[0], 32'hA5A5_1234);

        set_idle();
        dmem_req = 1'b1; acc_req = 2'b11; acc_addr = 16'h0302;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("fixed_rd_core_only", 32'(obs_ack[0]), 32'd1);
        end

        set_idle();
        imem_req = 1'b1; imem_addr = 32'h10;
        acc_req = 2'b01; acc_we = 2'b01; acc_addr = 16'h0004; acc_wdata = {32'h0, 32'hDEAD_BEEF}; acc_be = 8'h0F;
        cycle();
        chk("rw_collide_old", imem_rdata_o[0], 32'hA5A5_1234);
        acc_req = 2'b00; acc_we = 2'b00;
        cycle();
        chk("rw_collide_new", imem_rdata_o[1], 32'hDEAD_BEEF);

        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            cycle();
        end

        // Reset lands while an acc1 read is completing: no rvalid, pointer back to 0.
        set_idle();
        acc_req = 2'b10; acc_addr = 16'h0700;
        @(posedge clk);
        #1 rst_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        chk("rst_rvalid_d0", 32'(acc_rvalid_o[0]), 32'd0);
        chk("rst_rvalid_d1", 32'(acc_rvalid_o[1]), 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        dmem_req = 1'b1; acc_req = 2'b11; acc_addr = 16'h0905;
        cycle();
        chk("rr_ptr_after_rst", 32'(obs_ack[1]), 32'd1);
        cycle();
        chk("rr_second_after_rst", 32'(obs_ack[1]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
